// File: rtl/prog_loader.sv
// prog_loader: accepts a program over a valid/ready word stream, writes it into
// instruction memory and releases the CPU from reset once the image is in place.
//
// Optional feature: define PROG_LOADER_CHECKSUM_EN to require a trailing 32-bit
// mod-2^32 sum of the payload words; a mismatch parks the loader in ERR.
//
// Ports:
//   clk, rst            sole clock, synchronous active-high reset
//   s_valid/s_ready/s_data  load stream (header, payload, [checksum])
//   restart             single-cycle request to return to IDLE
//   imem_we/imem_addr/imem_wdata  instruction-memory write port
//   cpu_rst_n           active-low CPU reset, high only while running
//   busy, done, error   loading / running / failed status
//   loaded_count        payload words written since the last header
module prog_loader #(
  parameter int unsigned IMEM_DEPTH = 1024,
  parameter logic [15:0] MAGIC      = 16'hC0DE,
  localparam int unsigned AW        = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [31:0]   s_data,
  input  logic          restart,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_rst_n,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [15:0]   loaded_count
);

`ifdef PROG_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_CHK, ST_RUN, ST_ERR} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_ERR} state_t;
`endif

  state_t      state_q, state_d;
  logic [15:0] n_q;
  logic [15:0] cnt_q;
  logic        xfer_c;
  logic        hdr_ok_c;
  logic        last_c;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [31:0] sum_q;
`endif

  // Stream is open while waiting for header, payload or checksum; restart blocks it.
  always_comb begin
    s_ready = 1'b0;
    case (state_q)
      ST_IDLE, ST_LOAD: s_ready = !restart;
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CHK:           s_ready = !restart;
`endif
      default:          s_ready = 1'b0;
    endcase
  end

  assign xfer_c   = s_valid && s_ready;
  assign hdr_ok_c = (s_data[31:16] == MAGIC) && (s_data[15:0] != 16'd0) &&
                    (32'(s_data[15:0]) <= 32'(IMEM_DEPTH));
  assign last_c   = (cnt_q == n_q - 16'd1);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (xfer_c) state_d = hdr_ok_c ? ST_LOAD : ST_ERR;
      ST_LOAD: begin
        if (xfer_c && last_c) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_d = ST_CHK;
`else
          state_d = ST_RUN;
`endif
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CHK:  if (xfer_c) state_d = (s_data == sum_q) ? ST_RUN : ST_ERR;
`endif
      default: state_d = state_q;
    endcase
    if (restart) state_d = ST_IDLE;
  end

  // State, write port and status registers. done/cpu_rst_n require RUN on two
  // consecutive cycles so the CPU leaves reset strictly after the last write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      n_q          <= 16'd0;
      cnt_q        <= 16'd0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= 32'd0;
      cpu_rst_n    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      loaded_count <= 16'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q        <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      imem_we <= xfer_c && (state_q == ST_LOAD);
      if (xfer_c && (state_q == ST_IDLE)) begin
        n_q          <= s_data[15:0];
        cnt_q        <= 16'd0;
        loaded_count <= 16'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_q        <= 32'd0;
`endif
      end
      if (xfer_c && (state_q == ST_LOAD)) begin
        imem_addr    <= AW'(cnt_q);
        imem_wdata   <= s_data;
        cnt_q        <= cnt_q + 16'd1;
        loaded_count <= loaded_count + 16'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_q        <= sum_q + s_data;
`endif
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      busy  <= (state_d == ST_LOAD) || (state_d == ST_CHK);
`else
      busy  <= (state_d == ST_LOAD);
`endif
      error     <= (state_d == ST_ERR);
      done      <= (state_q == ST_RUN) && (state_d == ST_RUN);
      cpu_rst_n <= (state_q == ST_RUN) && (state_d == ST_RUN);
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized and directed bench for prog_loader with a small program-image model.
module tb_prog_loader;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [31:0]   s_data = 32'd0;
  logic          restart = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_rst_n, busy, done, error;
  logic [15:0]   loaded_count;

  prog_loader #(.IMEM_DEPTH(DEPTH), .MAGIC(16'hC0DE)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .restart(restart), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done),
    .error(error), .loaded_count(loaded_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  logic [31:0] pl[$];
  bit          overlap = 1'b0;

  always @(posedge clk) cyc++;

  // Observed write log; a write while the CPU runs or in ERR is illegal.
  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(32'(imem_addr));
      wr_data.push_back(imem_wdata);
      wr_cyc.push_back(cyc);
      if (cpu_rst_n || error) overlap = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Present one word from a negedge, wait for it to be taken, then idle 'stall' cycles.
  task automatic xfer(input logic [31:0] w, input int stall);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = w;
    #1;
    while (!s_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("xfer_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    s_valid = 1'b0;
    repeat (stall) @(negedge clk);
  endtask

  function automatic int pick_stall(input int stall);
    return (stall < 0) ? int'($urandom_range(0, 2)) : stall;
  endfunction

  // One complete load. Expected results come straight from the loading rules:
  // a good header writes payload[i] at address i; the end state is RUN or ERR.
  task automatic run_load(input logic [15:0] tag, input logic [15:0] n,
                          input bit bad_cks, input int stall);
    logic [31:0] sum;
    bit ok, run_exp;
    int nw;
    sum = 32'd0;
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    overlap = 1'b0;
    ok = (tag == 16'hC0DE) && (n != 16'd0) && (32'(n) <= DEPTH);
    xfer({tag, n}, pick_stall(stall));
    if (ok) begin
      if (pl.size() == 0) for (int i = 0; i < int'(n); i++) pl.push_back($urandom);
      for (int i = 0; i < int'(n); i++) begin
        xfer(pl[i], pick_stall(stall));
        sum += pl[i];
      end
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    if (ok) xfer(bad_cks ? (sum ^ 32'h0000_0001) : sum, 0);
    run_exp = ok && !bad_cks;
`else
    run_exp = ok;
`endif
    repeat (3) @(negedge clk);
    nw = ok ? int'(n) : 0;
    check("write_count", 32'(wr_addr.size()), 32'(nw));
    for (int i = 0; i < wr_addr.size() && i < nw; i++) begin
      check("write_addr", wr_addr[i], 32'(i));
      check("write_data", wr_data[i], pl[i]);
    end
    if (stall == 0 && wr_cyc.size() > 1)
      check("b2b_writes", 32'(wr_cyc[wr_cyc.size()-1] - wr_cyc[0]), 32'(wr_cyc.size() - 1));
    check("done", 32'(done), 32'(run_exp));
    check("cpu_rst_n", 32'(cpu_rst_n), 32'(run_exp));
    check("error", 32'(error), 32'(!run_exp));
    check("busy_end", 32'(busy), 32'd0);
    check("s_ready_end", 32'(s_ready), 32'd0);
    check("loaded_count", 32'(loaded_count), 32'(nw));
    check("no_overlap", 32'(overlap), 32'd0);
    restart = 1'b1;
    #1;
    check("s_ready_restart", 32'(s_ready), 32'd0);
    @(negedge clk);
    restart = 1'b0;
    #1;
    check("idle_s_ready", 32'(s_ready), 32'd1);
    check("idle_status", {29'd0, done, error, cpu_rst_n}, 32'd0);
    pl.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_status", {27'd0, cpu_rst_n, busy, done, error, s_ready}, 32'd1);
    check("rst_count", 32'(loaded_count), 32'd0);

    // Example image with back-to-back payload.
    pl = '{32'h11, 32'h22, 32'h33};
    run_load(16'hC0DE, 16'd3, 1'b0, 0);
    // Bad tag, zero length, oversize.
    run_load(16'hBEEF, 16'd2, 1'b0, 0);
    run_load(16'hC0DE, 16'd0, 1'b0, 0);
    run_load(16'hC0DE, 16'(DEPTH + 1), 1'b0, 0);
    // Full-depth image must not wrap.
    run_load(16'hC0DE, 16'(DEPTH), 1'b0, 0);
    // Stalled payload, then wrong checksum where supported.
    pl = '{32'h5, 32'h7};
    run_load(16'hC0DE, 16'd2, 1'b1, 4);

    // Restart collides with the second payload word of an N=4 load.
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    xfer(32'hC0DE_0004, 0);
    xfer(32'hDEAD_0001, 0);
    s_valid = 1'b1; s_data = 32'hDEAD_0002; restart = 1'b1;
    #1;
    check("restart_blocks", 32'(s_ready), 32'd0);
    @(negedge clk);
    s_valid = 1'b0; restart = 1'b0;
    #1;
    check("restart_idle", {30'd0, busy, s_ready}, 32'd1);
    check("restart_cpu", 32'(cpu_rst_n), 32'd0);
    check("restart_wr", 32'(wr_addr.size()), 32'd1);
    pl = '{32'hAA};
    run_load(16'hC0DE, 16'd1, 1'b0, 0);

    // Reset arrives together with the final payload word.
    xfer(32'hC0DE_0002, 0);
    xfer(32'h1234_5678, 0);
    s_valid = 1'b1; s_data = 32'h9ABC_DEF0; rst = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    check("rst_mid_we", 32'(imem_we), 32'd0);
    check("rst_mid_addr", 32'(imem_addr), 32'd0);
    check("rst_mid_wdata", imem_wdata, 32'd0);
    check("rst_mid_count", 32'(loaded_count), 32'd0);
    check("rst_mid_status", {28'd0, cpu_rst_n, busy, done, error}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Randomized loads, including occasional illegal headers and bad checksums.
    for (int it = 0; it < 25; it++) begin
      logic [15:0] tag, n;
      tag = ($urandom_range(0, 5) == 0) ? 16'($urandom) : 16'hC0DE;
      n   = 16'($urandom_range(0, DEPTH + 1));
      run_load(tag, n, ($urandom_range(0, 3) == 0), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
